// File: rtl/spi_host_arbiter.sv
// Round-robin transaction arbiter sharing one SPI byte engine between NumReq requesters.
// Optional idle-hold timeout is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_host_arbiter #(
    parameter int NumReq      = 2,
    parameter int IdleTimeout = 255
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic [NumReq-1:0]     rsp_valid_o,
    output logic [7:0]            rsp_data_o,
    output logic                  eng_start_o,
    output logic [7:0]            eng_data_o,
    input  logic                  eng_done_i,
    input  logic [7:0]            eng_data_i,
    output logic                  cs_no,
    output logic [NumReq-1:0]     grant_o,
    output logic                  timeout_o
);
    localparam int PtrW = (NumReq > 2) ? 2 : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, RELEASE} state_e;

    if (NumReq < 2 || NumReq > 4 || IdleTimeout < 1 || IdleTimeout > 255) begin : g_param_check
        $error("spi_host_arbiter: NumReq must be 2..4 and IdleTimeout 1..255");
    end

    state_e              state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic                cs_q, cs_d;
    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic                start_q, start_d;
    logic [7:0]          eng_data_q, eng_data_d;
    logic [NumReq-1:0]   ready_q, ready_d;
    logic [NumReq-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic                last_q, last_d;

    logic [NumReq-1:0]   hit_hi, cand, win_oh, sel_oh;
    logic [PtrW-1:0]     win_idx;
    logic [7:0]          data_term [NumReq];
    logic [7:0]          sel_data;
    logic                valid_g, last_g;

    // Requesters at or above the pointer take precedence; otherwise wrap to the lowest index.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        assign hit_hi[gi]    = req_valid_i[gi] & (PtrW'(gi) >= ptr_q);
        assign data_term[gi] = sel_oh[gi] ? req_data_i[8*gi +: 8] : 8'h00;
    end

    assign cand    = (|hit_hi) ? hit_hi : req_valid_i;
    assign win_oh  = cand & (~cand + NumReq'(1));
    assign sel_oh  = (state_q == IDLE) ? win_oh : grant_q;
    assign valid_g = |(req_valid_i & grant_q);
    assign last_g  = |(req_last_i & grant_q);

    always_comb begin
        win_idx  = '0;
        sel_data = 8'h00;
        for (int i = 0; i < NumReq; i++) begin
            if (win_oh[i]) win_idx = PtrW'(i);
            sel_data = sel_data | data_term[i];
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(IdleTimeout - 1);
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cs_d        = cs_q;
        ptr_d       = ptr_q;
        start_d     = 1'b0;
        eng_data_d  = eng_data_q;
        ready_d     = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
`ifdef SPI_ARB_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d    = ISSUE;
                    grant_d    = win_oh;
                    cs_d       = 1'b0;
                    ptr_d      = (win_idx == PtrW'(NumReq - 1)) ? '0 : win_idx + PtrW'(1);
                    start_d    = 1'b1;
                    ready_d    = win_oh;
                    eng_data_d = sel_data;
                end
            end
            ISSUE: begin
                last_d  = last_g;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done_i) begin
                    rsp_valid_d = grant_q;
                    rsp_data_d  = eng_data_i;
                    if (last_q) begin
                        state_d = RELEASE;
                        cs_d    = 1'b1;
                        grant_d = '0;
                    end else begin
                        state_d = HOLD;
`ifdef SPI_ARB_TIMEOUT_EN
                        idle_cnt_d = 8'h00;
`endif
                    end
                end
            end
            HOLD: begin
                if (valid_g) begin
                    state_d    = ISSUE;
                    start_d    = 1'b1;
                    ready_d    = grant_q;
                    eng_data_d = sel_data;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (idle_cnt_q == TimeoutLast) begin
                    state_d   = RELEASE;
                    cs_d      = 1'b1;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'h01;
`endif
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            cs_q        <= 1'b1;
            ptr_q       <= '0;
            start_q     <= 1'b0;
            eng_data_q  <= 8'h00;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h00;
            last_q      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            idle_cnt_q  <= 8'h00;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cs_q        <= cs_d;
            ptr_q       <= ptr_d;
            start_q     <= start_d;
            eng_data_q  <= eng_data_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
`ifdef SPI_ARB_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign eng_start_o = start_q;
    assign eng_data_o  = eng_data_q;
    assign cs_no       = cs_q;
    assign grant_o     = grant_q;

endmodule
